// File: rtl/shader_pkg.sv
// Shared types and helpers for the shader instruction consumer.
//  - shader_op_e  : legal opcode encodings
//  - instr_t      : {opcode, is_vector} payload at the default opcode width
//  - core_state_e : consumer FSM states
//  - op_latency() : execute cycles for an opcode/width pair
//  - is_legal_op(): opcode legality
package shader_pkg;

  localparam int unsigned SHADER_OPCODE_W = 4;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_MAC = 2'd3
  } shader_op_e;

  typedef struct packed {
    logic [SHADER_OPCODE_W-1:0] opcode;
    logic                       is_vector;
  } instr_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } core_state_e;

  function automatic logic is_legal_op(input int unsigned op);
    return op <= int'(OP_MAC);
  endfunction

  // Scalar latency per opcode, scaled by the lane count for vector instructions.
  function automatic int unsigned op_latency(input int unsigned op,
                                             input logic        is_vec,
                                             input int unsigned mul_lat,
                                             input int unsigned mac_lat,
                                             input int unsigned lanes);
    int unsigned base;
    case (op)
      int'(OP_MUL): base = mul_lat;
      int'(OP_MAC): base = mac_lat;
      default:      base = 32'd1;
    endcase
    return is_vec ? base * lanes : base;
  endfunction

endpackage

// File: rtl/shader_instr_fifo.sv
// Show-ahead synchronous FIFO holding accepted instructions.
//  clk, rst_n : clock, synchronous active-low reset (empties the FIFO)
//  push/wdata : write request and payload (ignored when full)
//  pop        : consume the head (ignored when empty)
//  full/empty : registered-count status
//  rdata      : current head, visible without popping
module shader_instr_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == OCC_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (do_pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + OCC_W'(1);
      2'b01:   count_d = count_q - OCC_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; only the bookkeeping is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/shader_instr_core.sv
// Consumer end of the shader instruction valid/ready channel.
// Buffers instructions, models per-opcode execute latency and retires one at a time.
//  clk, rst_n         : clock, synchronous active-low reset
//  valid/ready        : producer handshake; ready = FIFO not full (never depends on valid)
//  opcode, is_vector  : instruction payload (opcode >= 4 is illegal)
//  retire_valid       : one-cycle pulse when an instruction completes
//  retire_opcode/_is_vector : retiring instruction, held between pulses
//  illegal_op         : one-cycle pulse when an illegal opcode is dropped
//  busy               : executing or FIFO non-empty
//  retire_count, illegal_count : wrapping event counters
module shader_instr_core
  import shader_pkg::*;
#(
  parameter int unsigned OPCODE_W = 4,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MUL_LAT  = 2,
  parameter int unsigned MAC_LAT  = 3,
  parameter int unsigned LANES    = 4,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid,
  output logic                ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                is_vector,
  output logic                retire_valid,
  output logic [OPCODE_W-1:0] retire_opcode,
  output logic                retire_is_vector,
  output logic                illegal_op,
  output logic                busy,
  output logic [CNT_W-1:0]    retire_count,
  output logic [CNT_W-1:0]    illegal_count
);

  localparam int unsigned LAT_W   = $clog2(MAC_LAT * LANES + 1);
  localparam int unsigned ENTRY_W = OPCODE_W + 1;

  core_state_e         state_q, state_d;
  logic [LAT_W-1:0]    cnt_q, cnt_d;
  logic [OPCODE_W-1:0] ret_op_q, ret_op_d;
  logic                ret_vec_q, ret_vec_d;
  logic                illegal_q, illegal_d;
  logic                rdy_en_q, rdy_en_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0]    illegal_cnt_q, illegal_cnt_d;

  logic                fifo_full, fifo_empty, push, pop;
  logic [ENTRY_W-1:0]  head;
  logic [OPCODE_W-1:0] head_op;
  logic                head_vec, head_legal, exec_done, take_head;

  assign head_op    = head[ENTRY_W-1:1];
  assign head_vec   = head[0];
  assign head_legal = is_legal_op(32'(head_op));
  assign exec_done  = (state_q == ST_EXEC) && (cnt_q == '0);
  // The head is consumed from IDLE, or in the retire cycle so ADDs stream at one per cycle.
  assign take_head  = !fifo_empty && ((state_q == ST_IDLE) || exec_done);

  // rdy_en_q keeps ready low through reset and for the release cycle.
  assign ready = rdy_en_q && !fifo_full;
  assign push  = valid && ready;

  shader_instr_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({opcode, is_vector}),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .rdata (head)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (take_head && head_legal) state_d = ST_EXEC;
      ST_EXEC: if (exec_done) state_d = (take_head && head_legal) ? ST_EXEC : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pop, latency counter, retire registers and counters.
  always_comb begin
    pop           = 1'b0;
    cnt_d         = cnt_q;
    ret_op_d      = ret_op_q;
    ret_vec_d     = ret_vec_q;
    illegal_d     = 1'b0;
    rdy_en_d      = 1'b1;
    retire_cnt_d  = retire_cnt_q;
    illegal_cnt_d = illegal_cnt_q;
    if ((state_q == ST_EXEC) && (cnt_q != '0)) begin
      cnt_d = cnt_q - LAT_W'(1);
    end
    if (exec_done) begin
      retire_cnt_d = retire_cnt_q + CNT_W'(1);
    end
    if (take_head) begin
      pop = 1'b1;
      if (head_legal) begin
        cnt_d     = LAT_W'(op_latency(32'(head_op), head_vec, MUL_LAT, MAC_LAT, LANES) - 32'd1);
        ret_op_d  = head_op;
        ret_vec_d = head_vec;
      end else begin
        illegal_d     = 1'b1;
        illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      ret_op_q      <= '0;
      ret_vec_q     <= 1'b0;
      illegal_q     <= 1'b0;
      rdy_en_q      <= 1'b0;
      retire_cnt_q  <= '0;
      illegal_cnt_q <= '0;
    end else begin
      cnt_q         <= cnt_d;
      ret_op_q      <= ret_op_d;
      ret_vec_q     <= ret_vec_d;
      illegal_q     <= illegal_d;
      rdy_en_q      <= rdy_en_d;
      retire_cnt_q  <= retire_cnt_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  // A reset arriving during the final execute cycle suppresses that retire.
  assign retire_valid     = rst_n && exec_done;
  assign retire_opcode    = ret_op_q;
  assign retire_is_vector = ret_vec_q;
  assign illegal_op       = illegal_q;
  assign busy             = (state_q == ST_EXEC) || !fifo_empty;
  assign retire_count     = retire_cnt_q;
  assign illegal_count    = illegal_cnt_q;

endmodule

// File: tb/tb_shader_instr_core.sv
// Directed bench for shader_instr_core; a second instance with a 4-bit counter covers wrap.
module tb_shader_instr_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [3:0]  opcode;
  logic        is_vector;

  logic        ready, retire_valid, retire_is_vector, illegal_op, busy;
  logic [3:0]  retire_opcode;
  logic [15:0] retire_count, illegal_count;

  logic        w_ready, w_retire_valid, w_retire_is_vector, w_illegal_op, w_busy;
  logic [3:0]  w_retire_opcode;
  logic [3:0]  w_retire_count, w_illegal_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [4:0] ret_q[$];
  int         ret_cyc[$];
  int         ill_pulses = 0;

  always #5 clk = ~clk;

  shader_instr_core #(
    .OPCODE_W(4), .DEPTH(2), .MUL_LAT(2), .MAC_LAT(3), .LANES(4), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(ready),
    .opcode(opcode), .is_vector(is_vector),
    .retire_valid(retire_valid), .retire_opcode(retire_opcode),
    .retire_is_vector(retire_is_vector), .illegal_op(illegal_op), .busy(busy),
    .retire_count(retire_count), .illegal_count(illegal_count)
  );

  shader_instr_core #(
    .OPCODE_W(4), .DEPTH(2), .MUL_LAT(2), .MAC_LAT(3), .LANES(4), .CNT_W(4)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ready(w_ready),
    .opcode(opcode), .is_vector(is_vector),
    .retire_valid(w_retire_valid), .retire_opcode(w_retire_opcode),
    .retire_is_vector(w_retire_is_vector), .illegal_op(w_illegal_op), .busy(w_busy),
    .retire_count(w_retire_count), .illegal_count(w_illegal_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Record retire pulses (payload and cycle) and illegal pulses mid-cycle.
  always @(negedge clk) begin
    if (retire_valid === 1'b1) begin
      ret_q.push_back({retire_opcode, retire_is_vector});
      ret_cyc.push_back(cyc);
    end
    if (illegal_op === 1'b1) ill_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    ret_q.delete();
    ret_cyc.delete();
    ill_pulses = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
  endtask

  // Present one instruction until accepted; acc = cycle number of the accepting edge.
  task automatic send(input logic [3:0] op, input logic vec, output int acc);
    int n = 0;
    valid = 1'b1; opcode = op; is_vector = vec;
    while (!ready && n < 400) begin tick(); n++; end
    if (!ready) begin
      n_tests++; n_fail++;
      $display("FAIL send_timeout op=%0d ready=%b required 1", op, ready);
      valid = 1'b0; acc = -1;
      return;
    end
    tick();
    acc = cyc;
    valid = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin tick(); n++; end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle busy=%b required 0 after %0d cycles", busy, max);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; opcode = 4'd0; is_vector = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({ready, retire_valid, illegal_op, busy} !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_outputs cyc%0d rdy/rv/ill/busy=%b required 0000", i,
                 {ready, retire_valid, illegal_op, busy});
      end
      n_tests++;
      if (retire_count !== 16'd0 || illegal_count !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_counters ret=%0d ill=%0d required 0 0", retire_count, illegal_count);
      end
    end
    rst_n = 1'b1; valid = 1'b0;
    n_tests++;
    if (ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_release_ready ready=%b required 0", ready);
    end
    tick();
    n_tests++;
    if (ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready_rise ready=%b required 1", ready);
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_accept busy=%b required 0", busy);
    end
  endtask

  task automatic test_single_add();
    int acc;
    do_reset();
    send(4'd0, 1'b0, acc);
    wait_idle(50);
    n_tests++;
    if (ret_q.size() !== 1) begin
      n_fail++; $display("FAIL add_pulses got=%0d required 1", ret_q.size());
    end
    n_tests++;
    if (ret_q.size() > 0 && (ret_q[0] !== 5'b00000 || ret_cyc[0] !== acc + 1)) begin
      n_fail++;
      $display("FAIL add_retire op/vec=%b cyc=%0d required 00000 cyc=%0d", ret_q[0], ret_cyc[0], acc + 1);
    end
    n_tests++;
    if (retire_count !== 16'd1 || retire_opcode !== 4'd0) begin
      n_fail++;
      $display("FAIL add_count count=%0d op=%0d required 1 0", retire_count, retire_opcode);
    end
  endtask

  task automatic test_latency();
    int a0, a1, a2;
    logic [4:0] exp_q[3];
    int exp_c[3];
    do_reset();
    send(4'd3, 1'b0, a0);
    send(4'd3, 1'b1, a1);
    send(4'd2, 1'b1, a2);
    wait_idle(200);
    exp_q[0] = {4'd3, 1'b0}; exp_q[1] = {4'd3, 1'b1}; exp_q[2] = {4'd2, 1'b1};
    exp_c[0] = a0 + 3; exp_c[1] = exp_c[0] + 12; exp_c[2] = exp_c[1] + 8;
    n_tests++;
    if (ret_q.size() !== 3) begin
      n_fail++; $display("FAIL lat_pulses got=%0d required 3", ret_q.size());
    end
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (ret_q.size() > i && (ret_q[i] !== exp_q[i] || ret_cyc[i] !== exp_c[i])) begin
        n_fail++;
        $display("FAIL lat_retire%0d op/vec=%b cyc=%0d required %b cyc=%0d", i,
                 ret_q[i], ret_cyc[i], exp_q[i], exp_c[i]);
      end
    end
    n_tests++;
    if (retire_count !== 16'd3 || retire_opcode !== 4'd2 || retire_is_vector !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_final count=%0d op=%0d vec=%b required 3 2 1",
               retire_count, retire_opcode, retire_is_vector);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int n = 0;
    bit saw_low = 0;
    bit low_idle = 0;
    do_reset();
    valid = 1'b1; opcode = 4'd3; is_vector = 1'b1;
    while (acc < 4 && n < 500) begin
      if (ready) acc++;
      else begin
        saw_low = 1;
        if (!busy) low_idle = 1;
      end
      tick(); n++;
    end
    valid = 1'b0;
    wait_idle(200);
    n_tests++;
    if (saw_low !== 1'b1 || low_idle !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_low saw=%b while_idle=%b required 1 0", saw_low, low_idle);
    end
    n_tests++;
    if (ret_q.size() !== 4 || retire_count !== 16'd4) begin
      n_fail++;
      $display("FAIL bp_count pulses=%0d count=%0d required 4 4", ret_q.size(), retire_count);
    end
    for (int i = 1; i < 4; i++) begin
      n_tests++;
      if (ret_q.size() > i && (ret_q[i] !== {4'd3, 1'b1} || ret_cyc[i] - ret_cyc[i-1] !== 12)) begin
        n_fail++;
        $display("FAIL bp_retire%0d op/vec=%b gap=%0d required 00111 gap=12", i,
                 ret_q[i], ret_cyc[i] - ret_cyc[i-1]);
      end
    end
  endtask

  task automatic test_illegal();
    int a;
    do_reset();
    send(4'd0, 1'b0, a);
    send(4'd7, 1'b0, a);
    send(4'd0, 1'b0, a);
    wait_idle(50);
    tick();
    n_tests++;
    if (ill_pulses !== 1 || illegal_count !== 16'd1) begin
      n_fail++;
      $display("FAIL ill_count pulses=%0d count=%0d required 1 1", ill_pulses, illegal_count);
    end
    n_tests++;
    if (ret_q.size() !== 2 || retire_count !== 16'd2) begin
      n_fail++;
      $display("FAIL ill_retires pulses=%0d count=%0d required 2 2", ret_q.size(), retire_count);
    end
    n_tests++;
    if (ret_q.size() == 2 && (ret_q[0] !== 5'b00000 || ret_q[1] !== 5'b00000)) begin
      n_fail++; $display("FAIL ill_payload r0=%b r1=%b required 00000", ret_q[0], ret_q[1]);
    end
  endtask

  task automatic test_reset_mid_exec();
    int a;
    do_reset();
    send(4'd3, 1'b1, a);
    send(4'd0, 1'b0, a);
    repeat (4) tick();
    n_tests++;
    if (busy !== 1'b1 || ret_q.size() !== 0) begin
      n_fail++; $display("FAIL mid_busy busy=%b pulses=%0d required 1 0", busy, ret_q.size());
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || ready !== 1'b0 || retire_count !== 16'd0 || illegal_count !== 16'd0) begin
      n_fail++;
      $display("FAIL mid_reset busy=%b ready=%b ret=%0d ill=%0d required 0 0 0 0",
               busy, ready, retire_count, illegal_count);
    end
    repeat (20) tick();
    n_tests++;
    if (ret_q.size() !== 0 || busy !== 1'b0 || retire_count !== 16'd0 || ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_after pulses=%0d busy=%b ret=%0d ready=%b required 0 0 0 1",
               ret_q.size(), busy, retire_count, ready);
    end
  endtask

  task automatic test_wrap();
    int a;
    do_reset();
    for (int i = 0; i < 17; i++) send(4'd0, 1'b0, a);
    wait_idle(100);
    n_tests++;
    if (w_retire_count !== 4'd1 || retire_count !== 16'd17) begin
      n_fail++;
      $display("FAIL wrap_count w=%0d main=%0d required 1 17", w_retire_count, retire_count);
    end
    n_tests++;
    if (ret_q.size() !== 17 || w_busy !== 1'b0 || w_ready !== 1'b1 || w_retire_valid !== 1'b0 ||
        w_illegal_op !== 1'b0 || w_illegal_count !== 4'd0 ||
        w_retire_opcode !== 4'd0 || w_retire_is_vector !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_state pulses=%0d busy=%b ready=%b rv=%b ill=%b illc=%0d op=%0d vec=%b required 17 0 1 0 0 0 0 0",
               ret_q.size(), w_busy, w_ready, w_retire_valid, w_illegal_op, w_illegal_count,
               w_retire_opcode, w_retire_is_vector);
    end
  endtask

  initial begin
    rst_n = 1'b0; valid = 1'b0; opcode = 4'd0; is_vector = 1'b0;
    test_reset();
    test_single_add();
    test_latency();
    test_backpressure();
    test_illegal();
    test_reset_mid_exec();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
